// File: rtl/instr_mem_arbiter.sv
// Single-port instruction RAM controller: shares the RAM between core fetch and
// the program loader, holds fetch off until boot load completes, routes read responses.
module instr_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BOOT_HOLD  = 1,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rstn_i,
    input  logic                    fetch_req_i,
    input  logic [ADDR_WIDTH-1:0]   fetch_addr_i,
    output logic                    fetch_gnt_o,
    output logic                    fetch_rvalid_o,
    output logic [DATA_WIDTH-1:0]   fetch_rdata_o,
    input  logic                    ld_req_i,
    input  logic                    ld_we_i,
    input  logic [DATA_WIDTH/8-1:0] ld_be_i,
    input  logic [ADDR_WIDTH-1:0]   ld_addr_i,
    input  logic [DATA_WIDTH-1:0]   ld_wdata_i,
    output logic                    ld_gnt_o,
    output logic                    ld_rvalid_o,
    output logic [DATA_WIDTH-1:0]   ld_rdata_o,
    input  logic                    ld_done_i,
    output logic                    ram_en_o,
    output logic                    ram_we_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i,
    output logic                    core_fetch_en_o,
    output logic [CNT_WIDTH-1:0]    load_count_o
);

    localparam logic [0:0] ST_LOAD   = 1'b0;
    localparam logic [0:0] ST_RUN    = 1'b1;
    localparam logic [0:0] ST_RESET  = (BOOT_HOLD != 0) ? ST_LOAD : ST_RUN;

    localparam logic [1:0] OWN_NONE  = 2'd0;
    localparam logic [1:0] OWN_FETCH = 2'd1;
    localparam logic [1:0] OWN_LD    = 2'd2;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [0:0]           state_q, state_d;
    logic [1:0]           owner_q, owner_d;
    logic                 last_ld_q, last_ld_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= ST_RESET;
            owner_q   <= OWN_NONE;
            last_ld_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_ld_q <= last_ld_d;
            count_q   <= count_d;
        end
    end

    // Grant, RAM drive and next-state; last_ld_q only tracks RUN-phase arbitration
    always_comb begin
        state_d     = state_q;
        owner_d     = OWN_NONE;
        last_ld_d   = last_ld_q;
        count_d     = count_q;
        fetch_gnt_o = 1'b0;
        ld_gnt_o    = 1'b0;
        ram_en_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        ram_be_o    = '0;

        case (state_q)
            ST_LOAD: begin
                ld_gnt_o = ld_req_i;
                if (ld_done_i) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (fetch_req_i && ld_req_i) begin
                    if (last_ld_q) begin
                        fetch_gnt_o = 1'b1;
                    end else begin
                        ld_gnt_o = 1'b1;
                    end
                end else begin
                    fetch_gnt_o = fetch_req_i;
                    ld_gnt_o    = ld_req_i;
                end
            end
        endcase

        if (ld_gnt_o) begin
            owner_d    = OWN_LD;
            ram_en_o   = 1'b1;
            ram_addr_o = ld_addr_i;
            if (ld_we_i) begin
                ram_we_o    = 1'b1;
                ram_be_o    = ld_be_i;
                ram_wdata_o = ld_wdata_i;
                if (count_q != CNT_MAX) begin
                    count_d = count_q + CNT_WIDTH'(1);
                end
            end else begin
                ram_be_o = '1;
            end
            if (state_q == ST_RUN) begin
                last_ld_d = 1'b1;
            end
        end else if (fetch_gnt_o) begin
            owner_d    = OWN_FETCH;
            ram_en_o   = 1'b1;
            ram_addr_o = fetch_addr_i;
            ram_be_o   = '1;
            last_ld_d  = 1'b0;
        end
    end

    // Response routing: RAM data goes only to the port that owned last cycle's access
    assign fetch_rvalid_o  = (owner_q == OWN_FETCH);
    assign ld_rvalid_o     = (owner_q == OWN_LD);
    assign fetch_rdata_o   = fetch_rvalid_o ? ram_rdata_i : '0;
    assign ld_rdata_o      = ld_rvalid_o ? ram_rdata_i : '0;
    assign core_fetch_en_o = (state_q == ST_RUN);
    assign load_count_o    = count_q;

endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Scoreboard bench for instr_mem_arbiter with a behavioural registered RAM attached.
module tb_instr_mem_arbiter;

    logic        clk;
    logic        rstn;
    logic        fetch_req;
    logic [7:0]  fetch_addr;
    logic        fetch_gnt;
    logic        fetch_rvalid;
    logic [31:0] fetch_rdata;
    logic        ld_req;
    logic        ld_we;
    logic [3:0]  ld_be;
    logic [7:0]  ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_gnt;
    logic        ld_rvalid;
    logic [31:0] ld_rdata;
    logic        ld_done;
    logic        ram_en;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_be;
    logic [31:0] ram_rdata;
    logic        core_fetch_en;
    logic [1:0]  load_count;

    instr_mem_arbiter #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(32),
        .BOOT_HOLD (1),
        .CNT_WIDTH (2)
    ) dut (
        .clk            (clk),
        .rstn_i         (rstn),
        .fetch_req_i    (fetch_req),
        .fetch_addr_i   (fetch_addr),
        .fetch_gnt_o    (fetch_gnt),
        .fetch_rvalid_o (fetch_rvalid),
        .fetch_rdata_o  (fetch_rdata),
        .ld_req_i       (ld_req),
        .ld_we_i        (ld_we),
        .ld_be_i        (ld_be),
        .ld_addr_i      (ld_addr),
        .ld_wdata_i     (ld_wdata),
        .ld_gnt_o       (ld_gnt),
        .ld_rvalid_o    (ld_rvalid),
        .ld_rdata_o     (ld_rdata),
        .ld_done_i      (ld_done),
        .ram_en_o       (ram_en),
        .ram_we_o       (ram_we),
        .ram_addr_o     (ram_addr),
        .ram_wdata_o    (ram_wdata),
        .ram_be_o       (ram_be),
        .ram_rdata_i    (ram_rdata),
        .core_fetch_en_o(core_fetch_en),
        .load_count_o   (load_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Registered-read RAM, 64 words, read-before-write
    logic [31:0] mem [64];
    initial for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    always @(posedge clk) begin
        if (ram_en) begin
            ram_rdata <= mem[ram_addr[7:2]];
            if (ram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_be[b]) mem[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
                end
            end
        end
    end

    typedef struct {
        int unsigned cyc;
        logic        chk;
        logic [31:0] data;
    } exp_t;

    exp_t fq[$];
    exp_t lq[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic to_ld, input logic chk, input logic [31:0] data);
        exp_t e;
        e.cyc  = cyc + 1;
        e.chk  = chk;
        e.data = data;
        if (to_ld) lq.push_back(e);
        else       fq.push_back(e);
    endtask

    // Monitor: pop and compare whenever a port presents a response
    always @(negedge clk) begin
        exp_t e;
        if (fetch_rvalid) begin
            if (fq.size() == 0) begin
                check("fetch_unexpected_rvalid", 32'(fetch_rvalid), 32'h0);
            end else begin
                e = fq.pop_front();
                check("fetch_rvalid_cycle", e.cyc, cyc);
                if (e.chk) check("fetch_rdata", fetch_rdata, e.data);
                check("ld_rdata_nonowner", ld_rdata, 32'h0);
            end
        end
        if (ld_rvalid) begin
            if (lq.size() == 0) begin
                check("ld_unexpected_rvalid", 32'(ld_rvalid), 32'h0);
            end else begin
                e = lq.pop_front();
                check("ld_rvalid_cycle", e.cyc, cyc);
                if (e.chk) check("ld_rdata", ld_rdata, e.data);
                check("fetch_rdata_nonowner", fetch_rdata, 32'h0);
            end
        end
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic ld_op(input logic we, input logic [3:0] be, input logic [7:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd, input logic done);
        next_cycle();
        ld_req   = 1'b1;
        ld_we    = we;
        ld_be    = be;
        ld_addr  = addr;
        ld_wdata = wdata;
        ld_done  = done;
        @(negedge clk);
        check("ld_gnt", 32'(ld_gnt), 32'h1);
        push_exp(1'b1, !we, exp_rd);
    endtask

    task automatic go_idle;
        next_cycle();
        fetch_req = 1'b0;
        ld_req    = 1'b0;
        ld_we     = 1'b0;
        ld_done   = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rstn       = 1'b0;
        fetch_req  = 1'b1;
        fetch_addr = 8'h04;
        ld_req     = 1'b0;
        ld_we      = 1'b0;
        ld_be      = 4'h0;
        ld_addr    = 8'h00;
        ld_wdata   = 32'h0;
        ld_done    = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_fetch_gnt", 32'(fetch_gnt), 32'h0);
        check("rst_core_en", 32'(core_fetch_en), 32'h0);
        check("rst_load_count", 32'(load_count), 32'h0);
        check("rst_ram_en", 32'(ram_en), 32'h0);

        // Boot hold: fetch requested but not granted in LOAD
        next_cycle();
        rstn = 1'b1;
        @(negedge clk);
        check("load_fetch_gnt", 32'(fetch_gnt), 32'h0);
        check("load_core_en", 32'(core_fetch_en), 32'h0);

        ld_op(1'b1, 4'hF, 8'h04, 32'h0000_0013, 32'h0, 1'b0);
        check("load_fetch_gnt_w", 32'(fetch_gnt), 32'h0);
        check("ram_en_w", 32'(ram_en), 32'h1);
        check("ram_we_w", 32'(ram_we), 32'h1);
        check("ram_addr_w", 32'(ram_addr), 32'h04);
        check("ram_be_w", 32'(ram_be), 32'hF);
        check("ram_wdata_w", ram_wdata, 32'h0000_0013);

        ld_op(1'b0, 4'h0, 8'h04, 32'h0, 32'h0000_0013, 1'b0);
        check("ram_we_r", 32'(ram_we), 32'h0);
        check("ram_be_r", 32'(ram_be), 32'hF);
        check("count_after_1", 32'(load_count), 32'h1);

        // Byte-enable merge
        ld_op(1'b1, 4'hF, 8'h08, 32'h1122_3344, 32'h0, 1'b0);
        ld_op(1'b1, 4'h2, 8'h08, 32'hAABB_CCDD, 32'h0, 1'b0);
        ld_op(1'b0, 4'h0, 8'h08, 32'h0, 32'h1122_CC44, 1'b0);
        check("count_after_3", 32'(load_count), 32'h3);

        // ld_done with a loader write and a pending fetch
        ld_op(1'b1, 4'hF, 8'h0C, 32'hDEAD_BEEF, 32'h0, 1'b1);
        check("done_fetch_gnt", 32'(fetch_gnt), 32'h0);
        check("done_core_en", 32'(core_fetch_en), 32'h0);

        next_cycle();
        ld_req  = 1'b0;
        ld_done = 1'b0;
        @(negedge clk);
        check("run_fetch_gnt", 32'(fetch_gnt), 32'h1);
        check("run_core_en", 32'(core_fetch_en), 32'h1);
        check("run_ram_addr", 32'(ram_addr), 32'h04);
        push_exp(1'b0, 1'b1, 32'h0000_0013);

        // Conflict: fetch won last, so loader, fetch, loader, fetch
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            fetch_req  = 1'b1;
            fetch_addr = 8'h08;
            ld_req     = 1'b1;
            ld_we      = 1'b0;
            ld_addr    = 8'h0C;
            @(negedge clk);
            check("rr_ld_gnt", 32'(ld_gnt), 32'((i % 2) == 0));
            check("rr_fetch_gnt", 32'(fetch_gnt), 32'((i % 2) == 1));
            if ((i % 2) == 0) begin
                check("rr_ram_addr", 32'(ram_addr), 32'h0C);
                push_exp(1'b1, 1'b1, 32'hDEAD_BEEF);
            end else begin
                check("rr_ram_addr", 32'(ram_addr), 32'h08);
                push_exp(1'b0, 1'b1, 32'h1122_CC44);
            end
        end

        go_idle();
        check("idle_ram_en", 32'(ram_en), 32'h0);
        check("idle_ram_addr", 32'(ram_addr), 32'h0);
        check("idle_ram_be", 32'(ram_be), 32'h0);

        // Reset right after a fetch grant drops the response
        next_cycle();
        fetch_req  = 1'b1;
        fetch_addr = 8'h04;
        @(negedge clk);
        check("pre_rst_fetch_gnt", 32'(fetch_gnt), 32'h1);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        @(negedge clk);
        check("mid_rst_fetch_rvalid", 32'(fetch_rvalid), 32'h0);
        check("mid_rst_ld_rvalid", 32'(ld_rvalid), 32'h0);
        check("mid_rst_core_en", 32'(core_fetch_en), 32'h0);
        check("mid_rst_fetch_gnt", 32'(fetch_gnt), 32'h0);
        check("mid_rst_count", 32'(load_count), 32'h0);
        check("mid_rst_ram_en", 32'(ram_en), 32'h0);
        next_cycle();
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_fetch_gnt", 32'(fetch_gnt), 32'h0);
        check("post_rst_fetch_rvalid", 32'(fetch_rvalid), 32'h0);
        fetch_req = 1'b0;

        // Saturating counter, one write with be=0 still counts
        for (int i = 0; i < 5; i++) begin
            ld_op(1'b1, (i == 2) ? 4'h0 : 4'hF, 8'(8'h10 + 4 * i), 32'(i), 32'h0, 1'b0);
            check("sat_count", 32'(load_count), (i > 3) ? 32'h3 : 32'(i));
        end
        go_idle();
        check("sat_count_final", 32'(load_count), 32'h3);

        repeat (2) @(negedge clk);
        check("fetch_queue_drained", fq.size(), 32'h0);
        check("ld_queue_drained", lq.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_mem_arbiter.md
# instr_mem_arbiter

Controller and arbiter for the single-port instruction RAM. It shares the RAM's single access port between the core instruction-fetch port (read-only) and a program-loader port (read/write with byte enables). It also sequences boot: fetch is held off until the loader reports that the program image is in memory. It sits between the core/loader interconnect and the instruction RAM, and compensates for the RAM's one-cycle registered read latency with per-requester `rvalid` routing.

## Interface
- `ADDR_WIDTH`, 8: byte-address width; passed unchanged to the RAM.
- `DATA_WIDTH`, 32: data width; must be 32 (4 byte enables).
- `BOOT_HOLD`, 1: 1 = leave reset in LOAD state; 0 = leave reset in RUN state.
- `CNT_WIDTH`, 16: width of the loader write counter.
- `clk`  in  1  clock; single clock domain.
- `rstn_i`  in  1  reset, asynchronous, active-low.
- `fetch_req_i`  in  1  fetch read request.
- `fetch_addr_i`  in  ADDR_WIDTH  fetch byte address.
- `fetch_gnt_o`  out  1  fetch request accepted this cycle.
- `fetch_rvalid_o`  out  1  fetch read data valid.
- `fetch_rdata_o`  out  DATA_WIDTH  fetch read data.
- `ld_req_i`  in  1  loader request.
- `ld_we_i`  in  1  loader write (1) or read (0).
- `ld_be_i`  in  DATA_WIDTH/8  loader byte enables.
- `ld_addr_i`  in  ADDR_WIDTH  loader byte address.
- `ld_wdata_i`  in  DATA_WIDTH  loader write data.
- `ld_gnt_o`  out  1  loader request accepted.
- `ld_rvalid_o`  out  1  loader response; read data or write acknowledge.
- `ld_rdata_o`  out  DATA_WIDTH  loader read data.
- `ld_done_i`  in  1  single-cycle pulse: image loaded.
- `ram_en_o`, `ram_we_o`  out  1  RAM enable and write enable.
- `ram_addr_o`  out  ADDR_WIDTH  RAM byte address.
- `ram_wdata_o`  out  DATA_WIDTH  RAM write data.
- `ram_be_o`  out  DATA_WIDTH/8  RAM byte enables.
- `ram_rdata_i`  in  DATA_WIDTH  RAM read data; registered, valid one cycle after the access.
- `core_fetch_en_o`  out  1  core fetch enable; high in RUN.
- `load_count_o`  out  CNT_WIDTH  number of granted loader writes.

## Operation
**States**
- LOAD:
  - `fetch_gnt_o` = 0; `core_fetch_en_o` = 0.
  - Loader granted whenever `ld_req_i` = 1.
  - `ld_done_i` = 1 moves to RUN at the next edge.
- RUN:
  - `core_fetch_en_o` = 1.
  - Both ports are arbitrated.
  - `ld_done_i` is ignored.
  - There is no return to LOAD except through reset.

**Arbitration (RUN)**
- One grant per cycle.
- A single requester is always granted.
- When both request: round-robin. The port not granted most recently wins.
- The last-winner register resets to "fetch", so the loader wins the first conflict.

**RAM drive**
- On a granted access: `ram_en_o` = 1 and `ram_addr_o` = winner's address.
- Loader write: `ram_we_o` = 1, `ram_be_o` = `ld_be_i`, `ram_wdata_o` = `ld_wdata_i`.
- Read: `ram_we_o` = 0, `ram_be_o` = all ones.
- Idle: `ram_en_o`/`ram_we_o`/`ram_be_o` = 0, `ram_addr_o` = 0, `ram_wdata_o` = 0.

**Response routing**
- A registered owner tag (none/fetch/loader) records the grant.
- In the next cycle the owner's `rvalid` = 1. Its `rdata` = `ram_rdata_i`, routed combinationally.
- The non-owner's `rdata` is driven to 0.
- On a loader write, `ld_rvalid_o` still pulses; `ld_rdata_o` is don't-care (RAM read-before-write data).

**Counter**
- `load_count_o` += 1 on each granted loader write, including writes with `be` = 0.
- Saturates at 2^CNT_WIDTH−1; cleared only by reset.

**Addresses**
- Passed through unmodified; the RAM drops the low 2 bits.
- No alignment checking.

## Timing
**Reset values** (asynchronous, on `rstn_i` = 0)
- State = LOAD if `BOOT_HOLD`, else RUN.
- Owner = none.
- All `rvalid` = 0; `load_count_o` = 0.
- `core_fetch_en_o` = !`BOOT_HOLD`.
- `gnt` outputs are combinational, gated by state.

**Handshake and latency**
- Grant is combinational in the same cycle as `req`. The requester may change `addr`/`req` after the grant edge.
- Response latency is exactly 1 cycle after the grant. Back-to-back grants give one response per cycle; throughput is 1 access/cycle.
- A requester whose `req` is dropped before a grant gets no response.

**Boundary conditions**
- `ld_done_i` together with a fetch request in the same LOAD cycle: fetch is not granted that cycle and is granted from the next cycle.
- `ld_done_i` together with a loader write: the write is granted and counted, and the transition still occurs.
- Reset asserted mid-transaction: the outstanding response is dropped and no `rvalid` is emitted after reset.
- Counter at maximum plus another write: holds at maximum.

## Test plan
- Reset with `BOOT_HOLD`=1, `fetch_req_i`=1 held → `fetch_gnt_o`=0 and `core_fetch_en_o`=0 until the cycle after the `ld_done_i` pulse, then `fetch_gnt_o`=1.
- Loader writes `0x00000013` to addr 0x04 with `be`=0xF, then reads 0x04 → `ld_rvalid_o` one cycle after each grant; read returns `0x00000013`; `load_count_o`=1.
- Byte-enable write `be`=0x2, data `0xAABBCCDD`, over word `0x11223344` → read back `0x1122CC44`.
- RUN, both requesting continuously for 4 cycles → grants alternate loader, fetch, loader, fetch; each `rvalid` goes only to its owner, with the correct data.
- `CNT_WIDTH`=2, 5 loader writes → `load_count_o` reads 1, 2, 3, 3, 3.
- Assert `rstn_i` low in the cycle after a fetch grant → no `fetch_rvalid_o`, state returns to LOAD, all outputs at their reset values.
